and_gate_core: RTL and testbench
================================

Name: and_gate_core

Overview:
Registered, parameterizable bitwise AND stage with a valid/ready handshake on both sides.
- Computes y = a & b per bit.
- Also produces reduction flags and a ones-count of the result.
- Sits as a leaf datapath element; the interface bundle drives a/b and samples y.
- Default WIDTH=1 reproduces the plain 2-input AND gate function, with one cycle of latency.

Parameters:
WIDTH, 1, bit width of operands a, b and result y (legal range 1..64).
CNT_W, $clog2(WIDTH+1), width of y_ones; derived, not overridden by users.

Ports:
clk  input  1  rising-edge clock for all state.
rst  input  1  synchronous, active-high reset.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
in_valid  input  1  a/b are valid this cycle.
in_ready  output  1  stage can accept a/b this cycle.
y  output  WIDTH  registered result a & b.
out_valid  output  1  y and flags hold a valid result.
out_ready  input  1  downstream accepts the result this cycle.
y_ones  output  CNT_W  number of 1 bits in y.
y_all  output  1  y is all ones (&y).
y_any  output  1  y has at least one 1 bit (|y).

Behaviour:
- Single output register stage. in_ready = !out_valid || out_ready (combinational).
- Accept: in_valid && in_ready at a rising clk edge.
  - Loads y <= a & b and sets out_valid <= 1.
  - Loads y_ones/y_all/y_any computed from a & b in the same edge, so all outputs are mutually consistent.
- Drain: out_valid && out_ready with no new accept clears out_valid; y and flags hold their last values.
- Simultaneous drain and accept: the new result replaces the old one; out_valid stays 1. Full throughput is 1 result/cycle.
- Stall: out_valid && !out_ready forces in_ready=0; y, flags and out_valid hold stable. a/b are ignored.
- Latency: result is visible exactly 1 cycle after the accepting edge.
- Reset, synchronous, priority over all else: out_valid=0, y=0, y_ones=0, y_all=0, y_any=0.
  - in_ready=1 in the cycle after reset deasserts.
  - A reset mid-stall discards the held result.
- X on a/b while in_valid=0 must not propagate into state.
- No internal FSM beyond the out_valid bit.

Optional Feature:
Macro AND_GATE_NAND_EN.
- Defined:
  - Adds input port nand_mode (1 bit), sampled with the operands at accept.
  - When 1, the stored result is ~(a & b); y_ones/y_all/y_any are computed on the inverted value.
  - nand_mode has no effect while not accepting.
- Undefined: no nand_mode port; the result is always a & b.

Decomposition:
- Package and_gate_pkg:
  - DEFAULT_WIDTH=1.
  - Function cnt_width(w) returning $clog2(w+1).
  - Function popcount(logic [63:0] v, int w).
- One sub-module, and_gate_popcount: combinational ones-count of a WIDTH vector, instantiated on the pre-register result.
- Interface bundle intf carries a, b, y (and handshake signals) for benches.

Test Plan:
- Truth table, WIDTH=1, out_ready=1: (a,b) = 00,01,10,11 on consecutive cycles -> y = 0,0,0,1 one cycle later each; y_all = y_any = y; y_ones = y.
- Reset: after accepting a=b=1 -> y=1. Assert rst for 1 cycle -> out_valid=0, y=0, y_ones=0, y_all=0, y_any=0; in_ready=1 afterwards.
- Backpressure, WIDTH=8, out_ready=0:
  - Accept a=8'hF0, b=8'h3C -> y=8'h30, y_ones=2, y_all=0, y_any=1.
  - in_ready=0; offer a=8'hFF, b=8'hFF for 3 cycles -> y stays 8'h30.
  - Raise out_ready -> next accept yields y=8'hFF, y_ones=8, y_all=1.
- Back-to-back throughput, WIDTH=8, out_ready=1, in_valid=1 for 4 cycles with a=8'hFF, b=8'h01,8'h02,8'h04,8'h80 -> y=8'h01,8'h02,8'h04,8'h80 on 4 consecutive cycles; out_valid never drops.
- Zero result, WIDTH=8: a=8'hAA, b=8'h55 -> y=8'h00, y_any=0, y_ones=0.
- With AND_GATE_NAND_EN, WIDTH=4: nand_mode=1, a=4'hF, b=4'h3 -> y=4'hC, y_ones=2.

Source files
------------

// File: rtl/and_gate_pkg.sv
// Shared constants and helpers for the registered AND stage.
package and_gate_pkg;

   localparam int unsigned DEFAULT_WIDTH = 1;

   function automatic int unsigned cnt_width(input int unsigned w);
      return int'($clog2(w + 1));
   endfunction

   // Counts the ones in the low w bits of v.
   function automatic int unsigned popcount(input logic [63:0] v, input int w);
      logic [63:0]  t;
      int unsigned  n;
      t = v;
      n = 0;
      for (int i = 0; i < w; i++) begin
         n += {31'b0, t[0]};
         t = t >> 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/and_gate_intf.sv
// Signal bundle around one and_gate_core instance, used by benches.
interface and_gate_intf
   import and_gate_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] y_ones;
   logic             y_all;
   logic             y_any;

   modport producer (output a, b, in_valid, out_ready,
                     input  in_ready, y, out_valid, y_ones, y_all, y_any);
   modport stage    (input  a, b, in_valid, out_ready,
                     output in_ready, y, out_valid, y_ones, y_all, y_any);
endinterface

// File: rtl/and_gate_popcount.sv
// Combinational ones-count of a WIDTH-bit vector.
module and_gate_popcount
   import and_gate_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
   input  logic [WIDTH-1:0] v,
   output logic [CNT_W-1:0] ones
);

   logic [63:0] v_ext;

   always_comb begin
      v_ext = 64'(v);
      ones  = CNT_W'(popcount(v_ext, int'(WIDTH)));
   end

endmodule

// File: rtl/and_gate_core.sv
// Registered bitwise AND stage with valid/ready handshake and result flags.
// Optional inverted-result mode is enabled by defining AND_GATE_NAND_EN.
module and_gate_core
   import and_gate_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
`ifdef AND_GATE_NAND_EN
   input  logic             nand_mode,
`endif
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] y_ones,
   output logic             y_all,
   output logic             y_any
);

   logic [WIDTH-1:0] res;
   logic [CNT_W-1:0] res_ones;
   logic             accept;

   always_comb begin
`ifdef AND_GATE_NAND_EN
      res = nand_mode ? ~(a & b) : (a & b);
`else
      res = a & b;
`endif
      in_ready = !out_valid || out_ready;
      accept   = in_valid && in_ready;
   end

   and_gate_popcount #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_popcount (
      .v    (res),
      .ones (res_ones)
   );

   // Flags are registered alongside y so all outputs change on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
         y_ones    <= '0;
         y_all     <= 1'b0;
         y_any     <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         y         <= res;
         y_ones    <= res_ones;
         y_all     <= &res;
         y_any     <= |res;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_and_gate_core.sv
// Self-checking bench for and_gate_core: WIDTH=1 truth table, WIDTH=8 vector table and random run.
module tb_and_gate_core;
   import and_gate_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // WIDTH=1 instance
   logic a1, b1, iv1, ir1, y1, ov1, or1, yo1, ya1, yn1;
`ifdef AND_GATE_NAND_EN
   logic nm1 = 1'b0;
   logic nm8 = 1'b0;
`endif

   and_gate_core #(.WIDTH(1)) u1 (
`ifdef AND_GATE_NAND_EN
      .nand_mode (nm1),
`endif
      .clk (clk), .rst (rst), .a (a1), .b (b1), .in_valid (iv1), .in_ready (ir1),
      .y (y1), .out_valid (ov1), .out_ready (or1), .y_ones (yo1), .y_all (ya1), .y_any (yn1)
   );

   // WIDTH=8 instance through the bundle
   and_gate_intf #(.WIDTH(8)) bus ();

   and_gate_core #(.WIDTH(8)) u8 (
`ifdef AND_GATE_NAND_EN
      .nand_mode (nm8),
`endif
      .clk (clk), .rst (rst), .a (bus.a), .b (bus.b), .in_valid (bus.in_valid),
      .in_ready (bus.in_ready), .y (bus.y), .out_valid (bus.out_valid),
      .out_ready (bus.out_ready), .y_ones (bus.y_ones), .y_all (bus.y_all), .y_any (bus.y_any)
   );

`ifdef AND_GATE_NAND_EN
   logic [3:0] a4, b4, y4;
   logic       nm4, iv4, ir4, ov4, or4, ya4, yn4;
   logic [2:0] yo4;
   and_gate_core #(.WIDTH(4)) u4 (
      .nand_mode (nm4), .clk (clk), .rst (rst), .a (a4), .b (b4), .in_valid (iv4),
      .in_ready (ir4), .y (y4), .out_valid (ov4), .out_ready (or4), .y_ones (yo4),
      .y_all (ya4), .y_any (yn4)
   );
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       iv;
      logic       ordy;
      logic [7:0] y;
      int         ones;
      logic       all;
      logic       any;
      logic       ov;
      logic       ir;
   } vec_t;

   vec_t vt [14];

   task automatic chk8(input string tag, input logic [7:0] ey, input int eones,
                       input logic eall, input logic eany, input logic eov);
      chk({tag, ".y"},         64'(bus.y),         64'(ey));
      chk({tag, ".y_ones"},    64'(bus.y_ones),    64'(eones));
      chk({tag, ".y_all"},     64'(bus.y_all),     64'(eall));
      chk({tag, ".y_any"},     64'(bus.y_any),     64'(eany));
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(eov));
   endtask

   // Reference: one result slot, overwritten on accept, emptied on drain.
   logic       m_valid;
   logic [7:0] m_y;
   logic [7:0] ra, rb;
   logic       riv, rrdy, m_ready;

   initial begin
      rst = 1'b1;
      {a1, b1, iv1, or1} = '0;
      bus.a = '0; bus.b = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
`ifdef AND_GATE_NAND_EN
      {a4, b4, nm4, iv4, or4} = '0;
`endif
      vt[0]  = '{8'hF0, 8'h3C, 1, 0, 8'h30, 2, 0, 1, 1, 0};
      vt[1]  = '{8'hFF, 8'hFF, 1, 0, 8'h30, 2, 0, 1, 1, 0};
      vt[2]  = '{8'hFF, 8'hFF, 1, 0, 8'h30, 2, 0, 1, 1, 0};
      vt[3]  = '{8'hFF, 8'hFF, 1, 0, 8'h30, 2, 0, 1, 1, 0};
      vt[4]  = '{8'hFF, 8'hFF, 1, 1, 8'hFF, 8, 1, 1, 1, 1};
      vt[5]  = '{8'hFF, 8'h01, 1, 1, 8'h01, 1, 0, 1, 1, 1};
      vt[6]  = '{8'hFF, 8'h02, 1, 1, 8'h02, 1, 0, 1, 1, 1};
      vt[7]  = '{8'hFF, 8'h04, 1, 1, 8'h04, 1, 0, 1, 1, 1};
      vt[8]  = '{8'hFF, 8'h80, 1, 1, 8'h80, 1, 0, 1, 1, 1};
      vt[9]  = '{8'hAA, 8'h55, 1, 1, 8'h00, 0, 0, 0, 1, 1};
      vt[10] = '{8'hFF, 8'h0F, 1, 1, 8'h0F, 4, 0, 1, 1, 1};
      vt[11] = '{8'hxx, 8'hxx, 0, 1, 8'h0F, 4, 0, 1, 0, 1};
      vt[12] = '{8'hxx, 8'hxx, 0, 0, 8'h0F, 4, 0, 1, 0, 1};
      vt[13] = '{8'hC3, 8'h7E, 1, 0, 8'h42, 2, 0, 1, 1, 0};

      repeat (2) @(negedge clk);
      chk8("reset8", 8'h00, 0, 0, 0, 0);
      chk("reset1.y", 64'(y1), 64'd0);
      chk("reset1.out_valid", 64'(ov1), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset.in_ready", 64'(bus.in_ready), 64'd1);

      // WIDTH=1 truth table, one vector per cycle
      iv1 = 1'b1; or1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         {a1, b1} = 2'(i);
         @(negedge clk);
         chk($sformatf("tt%0d.y", i),      64'(y1),  64'(i == 3));
         chk($sformatf("tt%0d.y_ones", i), 64'(yo1), 64'(i == 3));
         chk($sformatf("tt%0d.y_all", i),  64'(ya1), 64'(i == 3));
         chk($sformatf("tt%0d.y_any", i),  64'(yn1), 64'(i == 3));
         chk($sformatf("tt%0d.out_valid", i), 64'(ov1), 64'd1);
      end

      // Reset after a one result
      a1 = 1'b1; b1 = 1'b1;
      @(negedge clk);
      chk("r1.y_before", 64'(y1), 64'd1);
      rst = 1'b1; iv1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("r1.y", 64'(y1), 64'd0);
      chk("r1.flags", 64'({ov1, yo1, ya1, yn1}), 64'd0);
      @(negedge clk);
      chk("r1.in_ready", 64'(ir1), 64'd1);

      // WIDTH=8 vector table: inputs held for one edge, outputs checked after it
      for (int i = 0; i < 14; i++) begin
         bus.a = vt[i].a; bus.b = vt[i].b;
         bus.in_valid = vt[i].iv; bus.out_ready = vt[i].ordy;
         @(negedge clk);
         chk8($sformatf("vec%0d", i), vt[i].y, vt[i].ones, vt[i].all, vt[i].any, vt[i].ov);
         chk($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready), 64'(vt[i].ir));
      end

      // Reset while stalled discards the held 0x42
      bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; bus.in_valid = 1'b0;
      chk8("stall_rst", 8'h00, 0, 0, 0, 0);
      chk("stall_rst.in_ready", 64'(bus.in_ready), 64'd1);

`ifdef AND_GATE_NAND_EN
      nm4 = 1'b1; a4 = 4'hF; b4 = 4'h3; iv4 = 1'b1; or4 = 1'b1;
      @(negedge clk);
      chk("nand4.y", 64'(y4), 64'hC);
      chk("nand4.y_ones", 64'(yo4), 64'd2);
      iv4 = 1'b0; nm4 = 1'b0;
      @(negedge clk);
      chk("nand4.hold", 64'(y4), 64'hC);
      chk("nand4.drain", 64'(ov4), 64'd0);
`endif

      // Random run against the one-slot reference
      m_valid = 1'b0; m_y = '0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 400; c++) begin
         riv  = 1'($urandom_range(1));
         rrdy = ($urandom_range(3) != 0);
         ra   = 8'($urandom);
         rb   = 8'($urandom);
`ifdef AND_GATE_NAND_EN
         nm8 = 1'($urandom_range(1));
`endif
         bus.in_valid = riv; bus.out_ready = rrdy;
         if (!riv && $urandom_range(1) == 1) begin
            bus.a = 'x; bus.b = 'x;
         end else begin
            bus.a = ra; bus.b = rb;
         end
         m_ready = !m_valid || rrdy;
         #1;
         chk("rnd.in_ready", 64'(bus.in_ready), 64'(m_ready));
         if (riv && m_ready) begin
            m_valid = 1'b1;
`ifdef AND_GATE_NAND_EN
            m_y = nm8 ? ~(ra & rb) : (ra & rb);
`else
            m_y = ra & rb;
`endif
         end else if (rrdy) begin
            m_valid = 1'b0;
         end
         @(negedge clk);
         chk8("rnd", m_y, $countones(m_y), m_y == 8'hFF, m_y != 8'h00, m_valid);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
